lab3_cache_wide_mem_adapter: RTL and testbench

//  Memory-side responder for the 4B request/response protocol. Accepts single-word

---
 rtl/lab3_cache_wide_mem_adapter_if.sv | 23 ++
 rtl/lab3_cache_wide_mem_adapter.sv | 176 +++++++++++++++++
 tb/tb_lab3_cache_wide_mem_adapter.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lab3_cache_wide_mem_adapter_if.sv
// Request/response channel bundle used on both sides of the wide-memory adapter.
// The master issues requests and accepts responses; the slave does the opposite.
interface lab3_cache_wide_mem_adapter_if #(
   parameter int REQ_W  = 77,
   parameter int RESP_W = 47
);
   logic [REQ_W-1:0]  req_msg;
   logic              req_val;
   logic              req_rdy;
   logic [RESP_W-1:0] resp_msg;
   logic              resp_val;
   logic              resp_rdy;

   modport master (
      output req_msg, req_val, resp_rdy,
      input  req_rdy, resp_msg, resp_val
   );

   modport slave (
      input  req_msg, req_val, resp_rdy,
      output req_rdy, resp_msg, resp_val
   );
endinterface

// File: rtl/lab3_cache_wide_mem_adapter.sv
// Single-line (64B) buffer serving 4B word requests from a 64B-wide memory.
// Define LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN for write-through instead of write-back.
module lab3_cache_wide_mem_adapter (
   input  logic                                 clk,
   input  logic                                 reset,
   lab3_cache_wide_mem_adapter_if.slave         nmem,
   lab3_cache_wide_mem_adapter_if.master        wmem
);
   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_EVICT_REQ  = 4'd1;
   localparam logic [3:0] S_EVICT_WAIT = 4'd2;
   localparam logic [3:0] S_FILL_REQ   = 4'd3;
   localparam logic [3:0] S_FILL_WAIT  = 4'd4;
   localparam logic [3:0] S_ACCESS     = 4'd5;
   localparam logic [3:0] S_RESP       = 4'd6;
`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
   localparam logic [3:0] S_WT_REQ     = 4'd7;
   localparam logic [3:0] S_WT_WAIT    = 4'd8;
`endif

   localparam logic [2:0] TYPE_RD = 3'd0;
   localparam logic [2:0] TYPE_WR = 3'd1;

   logic [3:0]   state_q,   state_d;
   logic         valid_q,   valid_d;
   logic         dirty_q,   dirty_d;
   logic [25:0]  tag_q,     tag_d;
   logic [511:0] line_q,    line_d;
   logic [2:0]   rtype_q,   rtype_d;
   logic [7:0]   ropaque_q, ropaque_d;
   logic [31:0]  raddr_q,   raddr_d;
   logic [31:0]  rdata_q,   rdata_d;
   logic [31:0]  rword_q,   rword_d;

   logic [2:0]   wreq_type;
   logic [31:0]  wreq_addr;
   logic [511:0] wreq_data;
   logic         nreq_fire, nresp_fire, wreq_fire, wresp_fire;
   logic         is_wr;
   logic [8:0]   woff;
   logic         unused_bits;

   assign nreq_fire  = nmem.req_val  && nmem.req_rdy;
   assign nresp_fire = nmem.resp_val && nmem.resp_rdy;
   assign wreq_fire  = wmem.req_val  && wmem.req_rdy;
   assign wresp_fire = wmem.resp_val && wmem.resp_rdy;
   assign is_wr      = (rtype_q == TYPE_WR);
   assign woff       = {raddr_q[5:2], 5'b0};

   assign unused_bits = ^{nmem.req_msg[33:32], raddr_q[1:0], wmem.resp_msg[530:512]};

   // Moore outputs; every handshake is held off while reset is asserted
   always_comb begin
      nmem.req_rdy  = 1'b0;
      nmem.resp_val = 1'b0;
      wmem.req_val  = 1'b0;
      wmem.resp_rdy = 1'b0;
      wreq_type     = TYPE_RD;
      wreq_addr     = '0;
      wreq_data     = '0;
      if (!reset) begin
         case (state_q)
            S_IDLE: nmem.req_rdy = 1'b1;
            S_EVICT_REQ: begin
               wmem.req_val = 1'b1;
               wreq_type    = TYPE_WR;
               wreq_addr    = {tag_q, 6'b0};
               wreq_data    = line_q;
            end
            S_FILL_REQ: begin
               wmem.req_val = 1'b1;
               wreq_addr    = {raddr_q[31:6], 6'b0};
            end
            S_EVICT_WAIT, S_FILL_WAIT: wmem.resp_rdy = 1'b1;
            S_RESP: nmem.resp_val = 1'b1;
`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
            S_WT_REQ: begin
               wmem.req_val = 1'b1;
               wreq_type    = TYPE_WR;
               wreq_addr    = {tag_q, 6'b0};
               wreq_data    = line_q;
            end
            S_WT_WAIT: wmem.resp_rdy = 1'b1;
`endif
            default: ;
         endcase
      end
   end

   assign wmem.req_msg  = {wreq_type, 8'h00, wreq_addr, 6'd0, wreq_data};
   assign nmem.resp_msg = {rtype_q, ropaque_q, 2'b00, 2'b00, rword_q};

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      dirty_d   = dirty_q;
      tag_d     = tag_q;
      line_d    = line_q;
      rtype_d   = rtype_q;
      ropaque_d = ropaque_q;
      raddr_d   = raddr_q;
      rdata_d   = rdata_q;
      rword_d   = rword_q;
      case (state_q)
         S_IDLE: begin
            if (nreq_fire) begin
               rtype_d   = nmem.req_msg[76:74];
               ropaque_d = nmem.req_msg[73:66];
               raddr_d   = nmem.req_msg[65:34];
               rdata_d   = nmem.req_msg[31:0];
               if (valid_q && (tag_q == nmem.req_msg[65:40])) state_d = S_ACCESS;
               else if (dirty_q)                              state_d = S_EVICT_REQ;
               else                                           state_d = S_FILL_REQ;
            end
         end
         S_EVICT_REQ: if (wreq_fire) state_d = S_EVICT_WAIT;
         S_EVICT_WAIT: begin
            if (wresp_fire) begin
               dirty_d = 1'b0;
               state_d = S_FILL_REQ;
            end
         end
         S_FILL_REQ: if (wreq_fire) state_d = S_FILL_WAIT;
         S_FILL_WAIT: begin
            if (wresp_fire) begin
               line_d  = wmem.resp_msg[511:0];
               tag_d   = raddr_q[31:6];
               valid_d = 1'b1;
               dirty_d = 1'b0;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (is_wr) begin
               line_d[woff +: 32] = rdata_q;
               rword_d            = 32'd0;
`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
               state_d            = S_WT_REQ;
`else
               dirty_d            = 1'b1;
               state_d            = S_RESP;
`endif
            end else begin
               rword_d = line_q[woff +: 32];
               state_d = S_RESP;
            end
         end
         S_RESP: if (nresp_fire) state_d = S_IDLE;
`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
         S_WT_REQ:  if (wreq_fire)  state_d = S_WT_WAIT;
         S_WT_WAIT: if (wresp_fire) state_d = S_RESP;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Only control state is reset; line/tag contents are qualified by valid_q
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         valid_q <= 1'b0;
         dirty_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
      tag_q     <= tag_d;
      line_q    <= line_d;
      rtype_q   <= rtype_d;
      ropaque_q <= ropaque_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rword_q   <= rword_d;
   end
endmodule

// File: tb/tb_lab3_cache_wide_mem_adapter.sv
// Directed bench for lab3_cache_wide_mem_adapter with a zero-latency stallable wide memory.
module tb_lab3_cache_wide_mem_adapter;
`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
   localparam int WT = 1;
`else
   localparam int WT = 0;
`endif

   logic clk;
   logic reset;

   lab3_cache_wide_mem_adapter_if #(.REQ_W(77),  .RESP_W(47))  n_if ();
   lab3_cache_wide_mem_adapter_if #(.REQ_W(561), .RESP_W(531)) w_if ();

   lab3_cache_wide_mem_adapter dut (
      .clk   (clk),
      .reset (reset),
      .nmem  (n_if),
      .wmem  (w_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- wide memory model ----------------
   logic [511:0] mem    [0:1023];
   bit           mem_wr [0:1023];
   bit           mem_stall = 1'b0;
   logic         pend;
   logic [530:0] pend_msg;
   int           wreq_cnt;
   logic [2:0]   log_type [0:15];
   logic [31:0]  log_addr [0:15];
   logic [13:0]  log_oplen[0:15];
   logic [511:0] log_data [0:15];

   function automatic logic [511:0] init_line(input logic [31:0] la);
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = 32'h5A5A0000 + la + 32'(i * 4);
      if (la == 32'h0000_1000) l[31:0] = 32'hCAFE0001;
      if (la == 32'h0000_2000) begin
         l[31:0]  = 32'hBEEF2000;
         l[63:32] = 32'h12345678;
      end
      return l;
   endfunction

   logic [31:0]  m_addr;
   logic [9:0]   m_idx;
   logic [530:0] m_rsp;
   always_comb begin
      m_addr = w_if.req_msg[549:518];
      m_idx  = m_addr[15:6];
      m_rsp  = '0;
      if (w_if.req_msg[560:558] == 3'd1) m_rsp[530:528] = 3'd1;
      else m_rsp[511:0] = mem_wr[m_idx] ? mem[m_idx] : init_line({m_addr[31:6], 6'b0});
   end

   always @(posedge clk) begin
      if (reset) begin
         w_if.resp_val <= 1'b0;
         pend          <= 1'b0;
      end else begin
         if (w_if.resp_val && w_if.resp_rdy) w_if.resp_val <= 1'b0;
         if (w_if.req_val && w_if.req_rdy) begin
            log_type[wreq_cnt[3:0]]  <= w_if.req_msg[560:558];
            log_addr[wreq_cnt[3:0]]  <= m_addr;
            log_oplen[wreq_cnt[3:0]] <= {w_if.req_msg[557:550], w_if.req_msg[517:512]};
            log_data[wreq_cnt[3:0]]  <= w_if.req_msg[511:0];
            wreq_cnt <= wreq_cnt + 1;
            if (w_if.req_msg[560:558] == 3'd1) begin
               mem[m_idx]    <= w_if.req_msg[511:0];
               mem_wr[m_idx] <= 1'b1;
            end
            if (mem_stall) begin
               pend     <= 1'b1;
               pend_msg <= m_rsp;
            end else begin
               w_if.resp_val <= 1'b1;
               w_if.resp_msg <= m_rsp;
            end
         end else if (pend && !mem_stall) begin
            w_if.resp_val <= 1'b1;
            w_if.resp_msg <= pend_msg;
            pend          <= 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // One narrow transaction; lat = posedges from accept to response transfer, -1 on timeout.
   // nw = wide requests issued between accept and the response becoming valid.
   task automatic txn(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] d, output logic [46:0] resp, output int lat,
                      output int nw, output int base);
      int cyc;
      bit got;
      @(negedge clk);
      n_if.req_msg  = {t, op, a, 2'b00, d};
      n_if.req_val  = 1'b1;
      n_if.resp_rdy = 1'b1;
      cyc = 0;
      while (!n_if.req_rdy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      base = wreq_cnt;
      @(posedge clk);
      #1 n_if.req_val = 1'b0;
      lat  = 0;
      got  = 1'b0;
      resp = '0;
      nw   = -1;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (n_if.resp_val) begin
            resp = n_if.resp_msg;
            nw   = wreq_cnt - base;
            got  = 1'b1;
         end
         @(posedge clk);
      end
      #1;
      if (!got) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({n_if.resp_val, w_if.req_val, w_if.resp_rdy} !== 3'b000)
         $display("FAIL reset_outputs_during: got %b want 000", {n_if.resp_val, w_if.req_val, w_if.resp_rdy});
      else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (n_if.req_rdy !== 1'b1) $display("FAIL reset_nreq_rdy: got %b want 1", n_if.req_rdy);
      else n_pass++;
      n_checks++;
      if (n_if.resp_val !== 1'b0) $display("FAIL reset_nresp_val: got %b want 0", n_if.resp_val);
      else n_pass++;
      n_checks++;
      if ({w_if.req_val, w_if.resp_rdy} !== 2'b00)
         $display("FAIL reset_wide_idle: got %b want 00", {w_if.req_val, w_if.resp_rdy});
      else n_pass++;
   endtask

   task automatic test_read_miss();
      logic [46:0] r;
      int lat, nw, b;
      txn(3'd0, 8'h5A, 32'h0000_1000, 32'd0, r, lat, nw, b);
      n_checks++;
      if (nw !== 1) $display("FAIL rdmiss_nwreq: got %0d want 1", nw); else n_pass++;
      n_checks++;
      if ({log_type[b[3:0]], log_addr[b[3:0]]} !== {3'd0, 32'h0000_1000})
         $display("FAIL rdmiss_fill_req: got type %0d addr %h want type 0 addr 00001000", log_type[b[3:0]], log_addr[b[3:0]]);
      else n_pass++;
      n_checks++;
      if (log_oplen[b[3:0]] !== 14'd0) $display("FAIL rdmiss_wreq_oplen: got %h want 0", log_oplen[b[3:0]]);
      else n_pass++;
      n_checks++;
      if (r[31:0] !== 32'hCAFE0001) $display("FAIL rdmiss_data: got %h want cafe0001", r[31:0]);
      else n_pass++;
      n_checks++;
      if (r[46:32] !== {3'd0, 8'h5A, 4'd0}) $display("FAIL rdmiss_hdr: got %h want %h", r[46:32], {3'd0, 8'h5A, 4'd0});
      else n_pass++;
      n_checks++;
      if (lat !== 4) $display("FAIL rdmiss_latency: got %0d want 4", lat); else n_pass++;
   endtask

   task automatic test_write_hit();
      logic [46:0] r;
      int lat, nw, b;
      txn(3'd1, 8'h11, 32'h0000_1004, 32'h0000_DEAD, r, lat, nw, b);
      n_checks++;
      if (nw !== WT) $display("FAIL wrhit_nwreq: got %0d want %0d", nw, WT); else n_pass++;
      n_checks++;
      if (lat !== ((WT != 0) ? 4 : 2)) $display("FAIL wrhit_latency: got %0d want %0d", lat, (WT != 0) ? 4 : 2);
      else n_pass++;
      n_checks++;
      if (r !== {3'd1, 8'h11, 4'd0, 32'd0}) $display("FAIL wrhit_resp: got %h want %h", r, {3'd1, 8'h11, 4'd0, 32'd0});
      else n_pass++;
      txn(3'd0, 8'h12, 32'h0000_1004, 32'd0, r, lat, nw, b);
      n_checks++;
      if (nw !== 0) $display("FAIL rdhit_nwreq: got %0d want 0", nw); else n_pass++;
      n_checks++;
      if (r[31:0] !== 32'h0000_DEAD) $display("FAIL rdhit_data: got %h want 0000dead", r[31:0]);
      else n_pass++;
      n_checks++;
      if (lat !== 2) $display("FAIL rdhit_latency: got %0d want 2", lat); else n_pass++;
   endtask

   task automatic test_dirty_evict();
      logic [46:0] r;
      int lat, nw, b, fi;
      txn(3'd0, 8'h22, 32'h0000_2000, 32'd0, r, lat, nw, b);
      fi = b + ((WT != 0) ? 0 : 1);
      n_checks++;
      if (nw !== 2 - WT) $display("FAIL evict_nwreq: got %0d want %0d", nw, 2 - WT); else n_pass++;
`ifndef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
      n_checks++;
      if ({log_type[b[3:0]], log_addr[b[3:0]]} !== {3'd1, 32'h0000_1000})
         $display("FAIL evict_req: got type %0d addr %h want type 1 addr 00001000", log_type[b[3:0]], log_addr[b[3:0]]);
      else n_pass++;
      n_checks++;
      if (log_data[b[3:0]][63:0] !== {32'h0000_DEAD, 32'hCAFE0001})
         $display("FAIL evict_data: got %h want 0000deadcafe0001", log_data[b[3:0]][63:0]);
      else n_pass++;
`endif
      n_checks++;
      if ({log_type[fi[3:0]], log_addr[fi[3:0]]} !== {3'd0, 32'h0000_2000})
         $display("FAIL evict_fill_req: got type %0d addr %h want type 0 addr 00002000", log_type[fi[3:0]], log_addr[fi[3:0]]);
      else n_pass++;
      n_checks++;
      if (r[31:0] !== 32'hBEEF2000) $display("FAIL evict_rd_data: got %h want beef2000", r[31:0]);
      else n_pass++;
      n_checks++;
      if (lat !== 6 - 2 * WT) $display("FAIL evict_latency: got %0d want %0d", lat, 6 - 2 * WT); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [46:0] held;
      int cyc;
      bit bad_msg, bad_rdy;
      @(negedge clk);
      n_if.req_msg  = {3'd0, 8'h33, 32'h0000_2004, 2'b00, 32'd0};
      n_if.req_val  = 1'b1;
      n_if.resp_rdy = 1'b0;
      cyc = 0;
      while (!n_if.req_rdy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      #1 n_if.req_val = 1'b0;
      cyc = 0;
      while (!n_if.resp_val && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      held    = n_if.resp_msg;
      bad_msg = 1'b0;
      bad_rdy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (!n_if.resp_val || n_if.resp_msg !== held) bad_msg = 1'b1;
         if (n_if.req_rdy !== 1'b0) bad_rdy = 1'b1;
      end
      n_checks++;
      if (held !== {3'd0, 8'h33, 4'd0, 32'h12345678})
         $display("FAIL bp_resp: got %h want %h", held, {3'd0, 8'h33, 4'd0, 32'h12345678});
      else n_pass++;
      n_checks++;
      if (bad_msg !== 1'b0) $display("FAIL bp_stable: got unstable=%b want 0", bad_msg); else n_pass++;
      n_checks++;
      if (bad_rdy !== 1'b0) $display("FAIL bp_nreq_rdy_low: got violated=%b want 0", bad_rdy); else n_pass++;
      n_if.resp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({n_if.resp_val, n_if.req_rdy} !== 2'b01)
         $display("FAIL bp_after_xfer: got val,rdy=%b want 01", {n_if.resp_val, n_if.req_rdy});
      else n_pass++;
   endtask

   task automatic test_refill();
      logic [46:0] r;
      int lat, nw, b;
      txn(3'd0, 8'h66, 32'h0000_1004, 32'd0, r, lat, nw, b);
      n_checks++;
      if (nw !== 1) $display("FAIL refill_nwreq: got %0d want 1", nw); else n_pass++;
      n_checks++;
      if (r[31:0] !== 32'h0000_DEAD) $display("FAIL refill_data: got %h want 0000dead", r[31:0]);
      else n_pass++;
   endtask

`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
   task automatic test_write_through();
      logic [46:0] r;
      int lat, nw, b;
      txn(3'd1, 8'h77, 32'h0000_1008, 32'h0000_0055, r, lat, nw, b);
      n_checks++;
      if (nw !== 1) $display("FAIL wt_nwreq_before_resp: got %0d want 1", nw); else n_pass++;
      n_checks++;
      if ({log_type[b[3:0]], log_addr[b[3:0]]} !== {3'd1, 32'h0000_1000})
         $display("FAIL wt_req: got type %0d addr %h want type 1 addr 00001000", log_type[b[3:0]], log_addr[b[3:0]]);
      else n_pass++;
      n_checks++;
      if (log_data[b[3:0]][95:32] !== {32'h0000_0055, 32'h0000_DEAD})
         $display("FAIL wt_data: got %h want 000000550000dead", log_data[b[3:0]][95:32]);
      else n_pass++;
      n_checks++;
      if (r !== {3'd1, 8'h77, 4'd0, 32'd0}) $display("FAIL wt_resp: got %h want %h", r, {3'd1, 8'h77, 4'd0, 32'd0});
      else n_pass++;
   endtask
`endif

   task automatic test_reset_mid();
      logic [46:0] r;
      int lat, nw, b, cyc;
      bit saw_val;
      mem_stall = 1'b1;
      @(negedge clk);
      n_if.req_msg  = {3'd0, 8'h44, 32'h0000_3000, 2'b00, 32'd0};
      n_if.req_val  = 1'b1;
      n_if.resp_rdy = 1'b1;
      cyc = 0;
      while (!n_if.req_rdy && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      b = wreq_cnt;
      @(posedge clk);
      #1 n_if.req_val = 1'b0;
      cyc = 0;
      while (wreq_cnt == b && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      n_checks++;
      if (w_if.resp_rdy !== 1'b1) $display("FAIL rstmid_in_fill_wait: got wresp_rdy %b want 1", w_if.resp_rdy);
      else n_pass++;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      mem_stall = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({n_if.req_rdy, n_if.resp_val, w_if.req_val} !== 3'b100)
         $display("FAIL rstmid_after: got rdy,val,wval=%b want 100", {n_if.req_rdy, n_if.resp_val, w_if.req_val});
      else n_pass++;
      saw_val = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (n_if.resp_val !== 1'b0) saw_val = 1'b1;
      end
      n_checks++;
      if (saw_val !== 1'b0) $display("FAIL rstmid_no_resp: got resp seen=%b want 0", saw_val); else n_pass++;
      txn(3'd0, 8'h45, 32'h0000_1004, 32'd0, r, lat, nw, b);
      n_checks++;
      if (nw !== 1) $display("FAIL rstmid_reread_miss: got nwreq %0d want 1", nw); else n_pass++;
      n_checks++;
      if (r[31:0] !== 32'h0000_DEAD) $display("FAIL rstmid_reread_data: got %h want 0000dead", r[31:0]);
      else n_pass++;
   endtask

   initial begin
      reset         = 1'b1;
      n_if.req_val  = 1'b0;
      n_if.req_msg  = '0;
      n_if.resp_rdy = 1'b0;
      w_if.req_rdy  = 1'b1;
      test_reset();
      test_read_miss();
      test_write_hit();
      test_dirty_evict();
      test_backpressure();
      test_refill();
`ifdef LAB3_CACHE_WIDE_ADAPTER_WRITE_THROUGH_EN
      test_write_through();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
